// File: rtl/pkg_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// pkg_stream_decoder_if
// Link-side and event-side signals of one OFC channel package decoder.
//   master : link deserialiser / control side (drives live_rising, din_valid, din)
//   slave  : the decoder (drives header fields, energy stream and status)
// Signals:
//   live_rising          synchronous clear request
//   din_valid, din       16-bit ADC-link word stream
//   hdr_valid, r_*       decoded header fields, updated with hdr_valid
//   ene_valid/data/idx   energy word stream
//   pkg_done, pkg_ok     end-of-package status
//   hdr_err, len_err, eneword_err, ene_err_cnt, timeout_err   error reporting
// -----------------------------------------------------------------------------
interface pkg_stream_decoder_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 live_rising;
    logic                 din_valid;
    logic [15:0]          din;
    logic                 hdr_valid;
    logic [15:0]          r_pkglength;
    logic [28:0]          r_timestamp;
    logic [8:0]           r_spillno;
    logic [4:0]           r_slotno;
    logic [13:0]          r_evtno;
    logic                 ene_valid;
    logic [13:0]          ene_data;
    logic [11:0]          ene_idx;
    logic                 pkg_done;
    logic                 pkg_ok;
    logic                 hdr_err;
    logic                 len_err;
    logic                 eneword_err;
    logic [ERR_CNT_W-1:0] ene_err_cnt;
    logic                 timeout_err;

    modport master (
        output live_rising, din_valid, din,
        input  hdr_valid, r_pkglength, r_timestamp, r_spillno, r_slotno, r_evtno,
        input  ene_valid, ene_data, ene_idx, pkg_done, pkg_ok,
        input  hdr_err, len_err, eneword_err, ene_err_cnt, timeout_err
    );

    modport slave (
        input  live_rising, din_valid, din,
        output hdr_valid, r_pkglength, r_timestamp, r_spillno, r_slotno, r_evtno,
        output ene_valid, ene_data, ene_idx, pkg_done, pkg_ok,
        output hdr_err, len_err, eneword_err, ene_err_cnt, timeout_err
    );
endinterface

// File: rtl/pkg_stream_decoder.sv
// -----------------------------------------------------------------------------
// pkg_stream_decoder
// Streaming ADC-link package decoder: hunts SYNC_WORD, validates and decodes a
// six-word header, passes N_ENE energy words through with a format check,
// counts N_TRAIL trailer words and reports per-package status. Packages that
// stall for TIMEOUT consecutive invalid cycles are aborted.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  pkg_stream_decoder_if.slave (input stream in, decoded results out)
// All results are registered: they appear one cycle after the word is accepted.
// -----------------------------------------------------------------------------
module pkg_stream_decoder #(
    parameter logic [15:0] SYNC_WORD  = 16'h50BC,
    parameter int          N_ENE      = 1024,
    parameter int          N_TRAIL    = 6,
    parameter logic [15:0] EXP_PKGLEN = 16'd1036,
    parameter int          TIMEOUT    = 255,
    parameter int          ERR_CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    pkg_stream_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, HDR, ENE, TRAIL} state_t;

    typedef struct packed {
        logic                 hdr_valid;
        logic [15:0]          r_pkglength;
        logic [28:0]          r_timestamp;
        logic [8:0]           r_spillno;
        logic [4:0]           r_slotno;
        logic [13:0]          r_evtno;
        logic                 ene_valid;
        logic [13:0]          ene_data;
        logic [11:0]          ene_idx;
        logic                 pkg_done;
        logic                 pkg_ok;
        logic                 hdr_err;
        logic                 len_err;
        logic                 eneword_err;
        logic [ERR_CNT_W-1:0] ene_err_cnt;
        logic                 timeout_err;
    } out_t;

    localparam logic [11:0]          LAST_SLOT  = 12'd5;
    localparam logic [11:0]          LAST_ENE   = 12'(N_ENE - 1);
    localparam logic [11:0]          LAST_TRAIL = 12'((N_TRAIL > 0) ? N_TRAIL - 1 : 0);
    localparam logic [16:0]          GAP_LIMIT  = 17'(TIMEOUT);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = 1;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;     // header slot / energy index / trailer count
    logic [15:0] gap_q, gap_d;     // consecutive invalid cycles inside a package
    logic [15:0] hdr_q [0:4];      // header slots 0..4; slot 5 is taken straight from din
    out_t        out_q, out_d;

    logic        is_sync, hdr_word_ok, ene_word_ok, gap_expire;
    logic [15:0] pkglen_new;

    assign is_sync     = (bus.din == SYNC_WORD);
    assign hdr_word_ok = (bus.din[15:14] == 2'b11);
    assign ene_word_ok = (bus.din[15:14] == 2'b10);
    assign gap_expire  = !bus.din_valid && (state_q != IDLE)
                         && (({1'b0, gap_q} + 17'd1) == GAP_LIMIT);
    assign pkglen_new  = {hdr_q[0][7:0], hdr_q[1][7:0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // NOTE: header slots have no reset; fields are published only after all six slots of the current package were rewritten.
    always_ff @(posedge clk) begin
        if (state_q == HDR && bus.din_valid && !bus.live_rising && hdr_word_ok && cnt_q != LAST_SLOT)
            hdr_q[cnt_q[2:0]] <= bus.din;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        if (bus.live_rising) begin
            state_d = IDLE;
            cnt_d   = '0;
            gap_d   = '0;
        end else if (!bus.din_valid) begin
            if (gap_expire) begin
                state_d = IDLE;
                cnt_d   = '0;
                gap_d   = '0;
            end else if (state_q != IDLE) begin
                gap_d = gap_q + 16'd1;
            end
        end else begin
            gap_d = '0;
            unique case (state_q)
                IDLE: if (is_sync) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
                HDR: if (hdr_word_ok) begin
                    if (cnt_q == LAST_SLOT) begin
                        state_d = ENE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end else begin
                    // A broken header restarts immediately if the offending word is itself a sync.
                    state_d = is_sync ? HDR : IDLE;
                    cnt_d   = '0;
                end
                ENE: if (cnt_q == LAST_ENE) begin
                    state_d = (N_TRAIL == 0) ? IDLE : TRAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
                TRAIL: if (cnt_q == LAST_TRAIL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        out_d             = out_q;
        out_d.hdr_valid   = 1'b0;
        out_d.ene_valid   = 1'b0;
        out_d.pkg_done    = 1'b0;
        out_d.pkg_ok      = 1'b0;
        out_d.hdr_err     = 1'b0;
        out_d.timeout_err = 1'b0;
        if (bus.live_rising) begin
            out_d = '0;
        end else if (!bus.din_valid) begin
            out_d.timeout_err = gap_expire;
        end else begin
            unique case (state_q)
                IDLE: if (is_sync) begin
                    out_d.len_err     = 1'b0;
                    out_d.eneword_err = 1'b0;
                end
                HDR: if (!hdr_word_ok) begin
                    out_d.hdr_err = 1'b1;
                end else if (cnt_q == LAST_SLOT) begin
                    out_d.hdr_valid   = 1'b1;
                    out_d.r_pkglength = pkglen_new;
                    out_d.r_timestamp = {hdr_q[1][12], hdr_q[2][13:0], hdr_q[3][13:0]};
                    out_d.r_spillno   = {hdr_q[4][5], hdr_q[4][13:6]};
                    out_d.r_slotno    = hdr_q[4][4:0];
                    out_d.r_evtno     = bus.din[13:0];
                    out_d.len_err     = (pkglen_new != EXP_PKGLEN);
                end
                ENE: begin
                    out_d.ene_valid = 1'b1;
                    out_d.ene_data  = bus.din[13:0];
                    out_d.ene_idx   = cnt_q;
                    if (!ene_word_ok) begin
                        out_d.eneword_err = 1'b1;
                        if (out_q.ene_err_cnt != '1)
                            out_d.ene_err_cnt = out_q.ene_err_cnt + ERR_ONE;
                    end
                    // Without trailers the package closes on its last energy word,
                    // so that word's own error must already count against pkg_ok.
                    if (N_TRAIL == 0 && cnt_q == LAST_ENE) begin
                        out_d.pkg_done = 1'b1;
                        out_d.pkg_ok   = !(out_d.eneword_err || out_q.len_err);
                    end
                end
                TRAIL: if (cnt_q == LAST_TRAIL) begin
                    out_d.pkg_done = 1'b1;
                    out_d.pkg_ok   = !(out_q.eneword_err || out_q.len_err);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign bus.hdr_valid   = out_q.hdr_valid;
    assign bus.r_pkglength = out_q.r_pkglength;
    assign bus.r_timestamp = out_q.r_timestamp;
    assign bus.r_spillno   = out_q.r_spillno;
    assign bus.r_slotno    = out_q.r_slotno;
    assign bus.r_evtno     = out_q.r_evtno;
    assign bus.ene_valid   = out_q.ene_valid;
    assign bus.ene_data    = out_q.ene_data;
    assign bus.ene_idx     = out_q.ene_idx;
    assign bus.pkg_done    = out_q.pkg_done;
    assign bus.pkg_ok      = out_q.pkg_ok;
    assign bus.hdr_err     = out_q.hdr_err;
    assign bus.len_err     = out_q.len_err;
    assign bus.eneword_err = out_q.eneword_err;
    assign bus.ene_err_cnt = out_q.ene_err_cnt;
    assign bus.timeout_err = out_q.timeout_err;

endmodule

// File: tb/tb_pkg_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_pkg_stream_decoder
// Directed + randomized bench for pkg_stream_decoder. A monitor collects the
// DUT's header/energy/done events into queues; after each package the queues
// are compared against expectations computed from the package contents.
// A second instance with N_TRAIL=0 covers the trailer-less close.
// -----------------------------------------------------------------------------
module tb_pkg_stream_decoder;

    localparam int          N_ENE   = 1024;
    localparam int          N_TRAIL = 6;
    localparam int          TIMEOUT = 8;
    localparam int          ECW     = 16;
    localparam logic [15:0] SYNC    = 16'h50BC;
    localparam logic [15:0] EXP_LEN = 16'd1036;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        live = 1'b0;
    logic        dv   = 1'b0;
    logic        sel1 = 1'b0;
    logic [15:0] din  = '0;

    always #5 clk = ~clk;

    pkg_stream_decoder_if #(.ERR_CNT_W(ECW)) bus0 ();
    pkg_stream_decoder_if #(.ERR_CNT_W(ECW)) bus1 ();

    assign bus0.live_rising = live;
    assign bus0.din_valid   = dv & ~sel1;
    assign bus0.din         = din;
    assign bus1.live_rising = live;
    assign bus1.din_valid   = dv & sel1;
    assign bus1.din         = din;

    pkg_stream_decoder #(
        .SYNC_WORD(SYNC), .N_ENE(N_ENE), .N_TRAIL(N_TRAIL),
        .EXP_PKGLEN(EXP_LEN), .TIMEOUT(TIMEOUT), .ERR_CNT_W(ECW)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    pkg_stream_decoder #(
        .SYNC_WORD(SYNC), .N_ENE(4), .N_TRAIL(0),
        .EXP_PKGLEN(EXP_LEN), .TIMEOUT(TIMEOUT), .ERR_CNT_W(ECW)
    ) u_dut_nt (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic [15:0] len;
        logic [28:0] ts;
        logic [8:0]  sp;
        logic [4:0]  sl;
        logic [13:0] ev;
    } hdr_ev_t;

    logic [122:0] out0;
    assign out0 = {bus0.hdr_valid, bus0.r_pkglength, bus0.r_timestamp, bus0.r_spillno,
                   bus0.r_slotno, bus0.r_evtno, bus0.ene_valid, bus0.ene_data, bus0.ene_idx,
                   bus0.pkg_done, bus0.pkg_ok, bus0.hdr_err, bus0.len_err, bus0.eneword_err,
                   bus0.ene_err_cnt, bus0.timeout_err};

    int          n_checks      = 0;
    int          n_errors      = 0;
    int          exp_err_total = 0;
    int          hdr_err_n     = 0;
    int          to_n          = 0;
    logic [15:0] hdr_w [6];
    logic [15:0] ene_w [N_ENE];
    hdr_ev_t     hdr_evq [$];
    logic [25:0] ene_evq [$];
    logic [2:0]  done_evq [$];
    logic [13:0] done1q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.hdr_valid)
                hdr_evq.push_back({bus0.r_pkglength, bus0.r_timestamp, bus0.r_spillno,
                                   bus0.r_slotno, bus0.r_evtno});
            if (bus0.ene_valid) ene_evq.push_back({bus0.ene_idx, bus0.ene_data});
            if (bus0.pkg_done) begin
                done_evq.push_back({bus0.pkg_ok, bus0.len_err, bus0.eneword_err});
                check("done_exclusive", {bus0.hdr_valid, bus0.ene_valid}, 2'b00);
            end
            if (bus0.hdr_err)     hdr_err_n++;
            if (bus0.timeout_err) to_n++;
            if (bus1.pkg_done) done1q.push_back({bus1.ene_valid, bus1.ene_idx, bus1.pkg_ok});
        end
    end

    task automatic send(input logic [15:0] w);
        dv  = 1'b1;
        din = w;
        @(posedge clk);
        #1;
        dv  = 1'b0;
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_gap(input logic [15:0] w, input int max_gap);
        if (max_gap > 0 && $urandom_range(0, 15) == 0) idle($urandom_range(1, max_gap));
        send(w);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == SYNC) w = 16'h0000;
        return w;
    endfunction

    task automatic set_hdr_plan();
        hdr_w[0] = 16'hC004; hdr_w[1] = 16'hD00C; hdr_w[2] = 16'hC123;
        hdr_w[3] = 16'hC456; hdr_w[4] = 16'hC8A3; hdr_w[5] = 16'hC007;
    endtask

    task automatic set_hdr_rand(input logic bad_len);
        for (int i = 0; i < 6; i++) hdr_w[i] = {2'b11, 14'($urandom)};
        hdr_w[0][7:0] = 8'h04;
        hdr_w[1][7:0] = bad_len ? 8'($urandom_range(0, 255)) : 8'h0C;
        if (bad_len && hdr_w[1][7:0] == 8'h0C) hdr_w[1][7:0] = 8'h0D;
    endtask

    // bad_rate 0: all words well-formed; otherwise roughly one in bad_rate is malformed
    task automatic gen_ene(input int bad_rate);
        logic [1:0] tag;
        for (int i = 0; i < N_ENE; i++) begin
            ene_w[i] = {2'b10, 14'($urandom)};
            if (bad_rate > 0 && $urandom_range(0, bad_rate - 1) == 0) begin
                tag = 2'($urandom_range(0, 2));
                if (tag == 2'b10) tag = 2'b11;
                ene_w[i][15:14] = tag;
            end
        end
    endtask

    task automatic send_pkg(input int max_gap, input int n_ene, input int n_trail);
        send(SYNC);
        for (int i = 0; i < 6; i++)       send_gap(hdr_w[i], max_gap);
        for (int i = 0; i < n_ene; i++)   send_gap(ene_w[i], max_gap);
        for (int i = 0; i < n_trail; i++) send_gap(rand_word(), max_gap);
    endtask

    task automatic clear_mon();
        hdr_evq.delete();
        ene_evq.delete();
        done_evq.delete();
        done1q.delete();
        hdr_err_n = 0;
        to_n      = 0;
    endtask

    function automatic hdr_ev_t exp_hdr();
        hdr_ev_t e;
        e.len = {hdr_w[0][7:0], hdr_w[1][7:0]};
        e.ts  = {hdr_w[1][12], hdr_w[2][13:0], hdr_w[3][13:0]};
        e.sp  = {hdr_w[4][5], hdr_w[4][13:6]};
        e.sl  = hdr_w[4][4:0];
        e.ev  = hdr_w[5][13:0];
        return e;
    endfunction

    task automatic check_ene(input string tag, input int n);
        int mism;
        mism = 0;
        check({tag, "_ene_count"}, ene_evq.size(), n);
        for (int i = 0; i < ene_evq.size() && i < n; i++)
            if (ene_evq[i] !== {12'(i), ene_w[i][13:0]}) mism++;
        check({tag, "_ene_words"}, mism, 0);
    endtask

    task automatic check_pkg(input string tag, input int exp_hdr_err);
        int          nbad;
        logic [15:0] len;
        logic        exp_ok;
        idle(3);
        nbad = 0;
        for (int i = 0; i < N_ENE; i++) if (ene_w[i][15:14] != 2'b10) nbad++;
        len           = {hdr_w[0][7:0], hdr_w[1][7:0]};
        exp_ok        = (nbad == 0) && (len == EXP_LEN);
        exp_err_total = (exp_err_total + nbad > 65535) ? 65535 : exp_err_total + nbad;
        check({tag, "_hdr_count"}, hdr_evq.size(), 1);
        if (hdr_evq.size() > 0) check({tag, "_hdr_fields"}, hdr_evq[0], exp_hdr());
        check_ene(tag, N_ENE);
        check({tag, "_done_count"}, done_evq.size(), 1);
        if (done_evq.size() > 0)
            check({tag, "_ok_len_ene"}, done_evq[0], {exp_ok, len != EXP_LEN, nbad != 0});
        check({tag, "_err_cnt"}, bus0.ene_err_cnt, exp_err_total);
        check({tag, "_hdr_err_pulses"}, hdr_err_n, exp_hdr_err);
        check({tag, "_timeouts"}, to_n, 0);
        clear_mon();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out0, '0);
        rst = 1'b0;
        idle(2);
        check("post_reset_outputs", out0, '0);

        // Clean package from the test plan
        set_hdr_plan();
        for (int i = 0; i < N_ENE; i++) ene_w[i] = 16'h8000 + 16'(i);
        send_pkg(0, N_ENE, N_TRAIL);
        check_pkg("clean", 0);
        check("clean_pkglength", bus0.r_pkglength, 16'h040C);
        check("clean_slotno", bus0.r_slotno, 5'd3);
        check("clean_evtno", bus0.r_evtno, 14'h0007);

        // Bad energy words 5 and 1023 (last)
        ene_w[5]    = 16'h4000;
        ene_w[1023] = 16'h4000;
        send_pkg(0, N_ENE, N_TRAIL);
        check_pkg("bad_ene", 0);

        // Header break on a sync word, then resync
        for (int i = 0; i < N_ENE; i++) ene_w[i] = 16'h8000 + 16'(i);
        send(SYNC);
        send(16'hC004);
        send_pkg(0, N_ENE, N_TRAIL);
        check_pkg("resync", 1);

        // Length mismatch
        hdr_w[1] = 16'hC000;
        send_pkg(0, N_ENE, N_TRAIL);
        check_pkg("len_mismatch", 0);
        check("len_mismatch_pkglength", bus0.r_pkglength, 16'h0400);

        // Randomized packages with gaps below the timeout
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(0, 3)) send(rand_word());
            set_hdr_rand($urandom_range(0, 2) == 0);
            gen_ene(48);
            if (p == 1) ene_w[17] = SYNC;   // sync inside energy block is plain data
            send_pkg(TIMEOUT - 1, N_ENE, N_TRAIL);
            check_pkg("rand", 0);
        end

        // Timeout: (TIMEOUT-1)-cycle gaps survive, a TIMEOUT-cycle gap aborts
        set_hdr_plan();
        gen_ene(0);
        send(SYNC);
        for (int i = 0; i < 6; i++) send(hdr_w[i]);
        for (int i = 0; i < 100; i++) begin
            if (i == 30 || i == 61) idle(TIMEOUT - 1);
            send(ene_w[i]);
        end
        idle(TIMEOUT);
        idle(3);
        check("timeout_pulses", to_n, 1);
        check("timeout_no_done", done_evq.size(), 0);
        check("timeout_hdr_count", hdr_evq.size(), 1);
        check_ene("timeout", 100);
        check("timeout_err_cnt", bus0.ene_err_cnt, exp_err_total);
        clear_mon();
        send_pkg(TIMEOUT - 1, N_ENE, N_TRAIL);
        check_pkg("after_timeout", 0);

        // live_rising during the trailer
        gen_ene(0);
        ene_w[10]  = 16'h4000;
        ene_w[700] = 16'hC000;
        send_pkg(0, N_ENE, 3);
        live = 1'b1;
        dv   = 1'b1;
        din  = 16'h8000;
        @(posedge clk);
        #1;
        live = 1'b0;
        dv   = 1'b0;
        check("live_clear_outputs", out0, '0);
        check("live_clear_err_cnt", bus0.ene_err_cnt, 0);
        exp_err_total = 0;
        for (int i = 0; i < 3; i++) send(rand_word());
        idle(3);
        check("live_no_done", done_evq.size(), 0);
        clear_mon();

        // Asynchronous reset in the middle of the energy block
        gen_ene(0);
        ene_w[3] = 16'h0123;
        send_pkg(0, 200, 0);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", out0, '0);
        idle(2);
        rst = 1'b0;
        exp_err_total = 0;
        idle(2);
        check("rst_no_done", done_evq.size(), 0);
        clear_mon();
        gen_ene(0);
        send_pkg(TIMEOUT - 1, N_ENE, N_TRAIL);
        check_pkg("after_rst", 0);

        // N_TRAIL=0 instance: pkg_done together with the last ene_valid
        sel1 = 1'b1;
        for (int p = 0; p < 2; p++) begin
            send(SYNC);
            for (int i = 0; i < 6; i++) send(hdr_w[i]);
            for (int i = 0; i < 4; i++) send((p == 0 && i == 3) ? 16'h4123 : 16'h8000 + 16'(i));
        end
        sel1 = 1'b0;
        idle(3);
        check("nt_done_count", done1q.size(), 2);
        if (done1q.size() == 2) begin
            check("nt_done_last_bad", done1q[0], {1'b1, 12'd3, 1'b0});
            check("nt_done_clean", done1q[1], {1'b1, 12'd3, 1'b1});
        end
        check("nt_err_cnt", bus1.ene_err_cnt, 1);
        clear_mon();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
